// File: rtl/sm_div_seq.sv
// Sequential restoring divider for sign-magnitude operands, one quotient bit per clock.
// Latency: WIDTH-1 cycles after acceptance (divide-by-zero completes on the accepting edge).
// Backpressure: one operation in flight; result held in DONE until out_ready, in_ready only in IDLE.
module sm_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int MW = WIDTH - 1;        // magnitude width, also the step count
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [MW-1:0]   dq;        // dividend bits shift out the top, quotient bits shift in the bottom
    logic [MW-1:0]   dvm;       // divisor magnitude
    logic [WIDTH-1:0] prem;     // partial remainder with one guard bit
    logic [CW-1:0]   cnt;
    logic            sq, sr;

    logic             accept;
    logic             dv_zero;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] prem_nxt;
    logic [MW-1:0]    qmag_fin;
    logic [MW-1:0]    rmag_fin;
    logic [MW-1:0]    dd_mag;

    assign accept  = in_valid && (state == IDLE);
    assign dd_mag  = dividend[MW-1:0];
    assign dv_zero = ~|divisor[MW-1:0];

    // One trial subtraction: shift in the next dividend bit, subtract, restore on borrow.
    always_comb begin
        shifted  = {prem[WIDTH-2:0], dq[MW-1]};
        diff     = {1'b0, shifted} - {2'b00, dvm};
        borrow   = diff[WIDTH];
        prem_nxt = borrow ? shifted : diff[WIDTH-1:0];
        qmag_fin = {dq[MW-2:0], ~borrow};
        rmag_fin = prem_nxt[MW-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake/status decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = dv_zero ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result commit; zero magnitudes never carry a sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq          <= '0;
            dvm         <= '0;
            prem        <= '0;
            cnt         <= '0;
            sq          <= 1'b0;
            sr          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dq   <= dd_mag;
            dvm  <= divisor[MW-1:0];
            sq   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sr   <= dividend[WIDTH-1];
            prem <= '0;
            cnt  <= CW'(MW);
            if (dv_zero) begin
                div_by_zero <= 1'b1;
                quotient    <= {dividend[WIDTH-1] ^ divisor[WIDTH-1], {MW{1'b1}}};
                remainder   <= {dividend[WIDTH-1] & (|dd_mag), dd_mag};
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            dq   <= qmag_fin;
            prem <= prem_nxt;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                quotient  <= {sq & (|qmag_fin), qmag_fin};
                remainder <= {sr & (|rmag_fin), rmag_fin};
            end
        end
    end

endmodule
